uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter (txuart, 8N1, same baud parameterisation as rxuart) between NUM_REQ byte-stream requesters. Each requester presents packets as byte streams with a last flag. Grant is held for a whole packet so bytes from different sources never interleave on the line. Sits between the on-chip producers and the single txuart instance at the FPGA pin.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- TAG_BASE, 8'hA0: tag byte base; tag = TAG_BASE | requester index (only with tag feature).
- i_clk  in  1  system clock (25 MHz).
- rst  in  1  synchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-requester byte valid.
- i_req_data  in  8*NUM_REQ  per-requester byte; requester k on bits [8k+7:8k].
- i_req_last  in  NUM_REQ  byte is last of packet.
- o_req_ready  out  NUM_REQ  byte accepted this cycle (valid && ready = transfer).
- o_grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- o_wr  out  1  one-cycle strobe to txuart.
- o_data  out  8  byte to txuart, valid when o_wr=1.
- i_busy  in  1  txuart busy; rises the cycle after o_wr, falls when stop bit done.

## Operation
- States: IDLE, TAG, DATA, STROBE, SETTLE.
- IDLE: if any i_req_valid, winner = first set bit searching from (ptr+1) mod NUM_REQ upward with wrap; o_grant <= onehot(winner), ptr <= winner; next TAG (feature on) or DATA.
- TAG: when i_busy=0, o_data <= TAG_BASE | winner, pkt_last <= 0; next STROBE. No ready asserted.
- DATA: o_req_ready[g] = (state==DATA) && !i_busy, combinational; other ready bits 0. On transfer: o_data <= i_req_data[g], pkt_last <= i_req_last[g]; next STROBE. Valid low keeps DATA indefinitely (grant held, no timeout).
- STROBE: o_wr=1 for exactly one cycle; next SETTLE.
- SETTLE: one cycle, i_busy ignored; next DATA if pkt_last=0, else IDLE with o_grant <= 0.
- Only the granted requester is ever readied; valid from others is ignored until IDLE.
- o_data holds its last value when o_wr=0.
- Reset values: state IDLE, o_grant 0, o_req_ready 0, o_wr 0, o_data 8'h00, ptr NUM_REQ-1 (requester 0 wins first), pkt_last 0.
- Reset mid-packet: immediate return to IDLE; partially sent packet is abandoned; no further strobes.

## Timing
- Valid in IDLE at cycle T -> o_grant at T+1.
- No tag, i_busy=0: ready at T+1, o_wr at T+2, SETTLE T+3, next ready earliest T+4.
- Tag: tag strobe T+2, first data ready earliest T+4 (only if i_busy already low).
- Per byte minimum 3 cycles of arbiter overhead; throughput otherwise bound by i_busy.
- Last byte: o_grant clears at exit of SETTLE; new arbitration decision one cycle later in IDLE.
- Simultaneous valid from all requesters: grant order strictly rotates 0,1,2,3,0,...
- Single requester repeatedly valid: regranted every packet with one IDLE cycle between.

## Configuration
- UART_ARB_SRC_TAG_EN defined: TAG state active; every packet preceded by one tag byte TAG_BASE | index.
- Undefined: TAG state and TAG_BASE logic compiled out; IDLE goes directly to DATA; line carries payload only.

## Structure
- Package uart_arb_pkg: state enum, IDX_W = $clog2(NUM_REQ) rule, default TAG_BASE constant.
- Sub-module rr_pick: combinational round-robin priority picker (request vector, ptr -> one-hot winner, index, any).
- Top holds FSM, ptr, grant, output registers; txuart instantiated outside.

## Test plan
- Req1 sends 3-byte packet 0x11,0x22,0x33(last), i_busy model 10 cycles/byte -> o_wr three times with those bytes, o_grant=0010 throughout, 0 after.
- All four valid continuously, 1-byte packets -> grant order 0,1,2,3,0; o_data sequence matches source bytes.
- Req0 valid 2-byte packet, drops valid for 20 cycles between bytes while req2 valid -> grant stays 0001, req2 starts only after req0 last.
- With UART_ARB_SRC_TAG_EN, req3 sends 0x5A(last) -> o_wr bytes 0xA3 then 0x5A; without macro only 0x5A.
- rst pulsed during STROBE of byte 2 of a packet -> next cycle o_wr=0, o_grant=0, state IDLE; next arbitration picks req0 first.
- i_busy held high 100 cycles in DATA -> o_req_ready stays 0, no o_wr until i_busy falls.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
package uart_arb_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StTag,
      StData,
      StStrobe,
      StSettle
   } arb_state_e;

   localparam logic [7:0] TagBaseDefault = 8'hA0;

   // Index width for a requester vector; never below one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr+1, wrapping.
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int unsigned NumReq = 4,
   parameter int unsigned IdxW   = idx_w(NumReq)
) (
   input  logic [NumReq-1:0] req_i,
   input  logic [IdxW-1:0]   ptr_i,
   output logic [NumReq-1:0] gnt_o,
   output logic [IdxW-1:0]   idx_o,
   output logic              any_o
);

   always_comb begin
      int unsigned     cand;
      logic [IdxW-1:0] cidx;
      cand  = 0;
      cidx  = '0;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int unsigned i = 1; i <= NumReq; i++) begin
         cand = (32'(ptr_i) + i) % NumReq;
         cidx = cand[IdxW-1:0];
         if (!any_o && req_i[cidx]) begin
            any_o       = 1'b1;
            idx_o       = cidx;
            gnt_o[cidx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one txuart among NUM_REQ byte streams.
// Define UART_ARB_SRC_TAG_EN to prefix every packet with a source tag byte.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
`ifdef UART_ARB_SRC_TAG_EN
   ,
   parameter logic [7:0]  TAG_BASE = TagBaseDefault
`endif
) (
   input  logic                   i_clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     i_req_valid,
   input  logic [8*NUM_REQ-1:0]   i_req_data,
   input  logic [NUM_REQ-1:0]     i_req_last,
   output logic [NUM_REQ-1:0]     o_req_ready,
   output logic [NUM_REQ-1:0]     o_grant,
   output logic                   o_wr,
   output logic [7:0]             o_data,
   input  logic                   i_busy
);

   localparam int unsigned IdxW = idx_w(NUM_REQ);

   arb_state_e         state_q, state_d;
   // ptr doubles as the owner index while a grant is held.
   logic [IdxW-1:0]    ptr_q, ptr_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [7:0]         data_q, data_d;
   logic               last_q, last_d;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IdxW-1:0]    pick_idx;
   logic               pick_any;
   logic               xfer;
   logic [7:0]         sel_data;
   logic               sel_last;

   rr_pick #(
      .NumReq (NUM_REQ),
      .IdxW   (IdxW)
   ) u_pick (
      .req_i (i_req_valid),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   assign sel_data = i_req_data[{ptr_q, 3'b000} +: 8];
   assign sel_last = i_req_last[ptr_q];
   assign xfer     = |(o_req_ready & i_req_valid);

   always_ff @(posedge i_clk) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= IdxW'(NUM_REQ - 1);
         grant_q <= '0;
         data_q  <= 8'h00;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      data_d  = data_q;
      last_d  = last_q;
      unique case (state_q)
         StIdle: begin
            if (pick_any) begin
               grant_d = pick_gnt;
               ptr_d   = pick_idx;
`ifdef UART_ARB_SRC_TAG_EN
               state_d = StTag;
`else
               state_d = StData;
`endif
            end
         end
`ifdef UART_ARB_SRC_TAG_EN
         StTag: begin
            if (!i_busy) begin
               data_d  = TAG_BASE | 8'(ptr_q);
               last_d  = 1'b0;
               state_d = StStrobe;
            end
         end
`endif
         StData: begin
            if (xfer) begin
               data_d  = sel_data;
               last_d  = sel_last;
               state_d = StStrobe;
            end
         end
         StStrobe: state_d = StSettle;
         // Busy only rises the cycle after the strobe, so it is not trusted here.
         StSettle: begin
            if (last_q) begin
               state_d = StIdle;
               grant_d = '0;
            end else begin
               state_d = StData;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      o_req_ready = '0;
      o_wr        = 1'b0;
      if (state_q == StData && !i_busy) o_req_ready = grant_q;
      if (state_q == StStrobe) o_wr = 1'b1;
   end

   assign o_grant = grant_q;
   assign o_data  = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random packets scored per source.
// Expectations follow UART_ARB_SRC_TAG_EN when defined.
module tb_uart_tx_arbiter;

   localparam int NUM = 4;
`ifdef UART_ARB_SRC_TAG_EN
   localparam logic [7:0] TAG_BASE = 8'hA0;
   localparam int TAG_N = 1;
`else
   localparam int TAG_N = 0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [NUM-1:0]   i_req_valid;
   logic [8*NUM-1:0] i_req_data;
   logic [NUM-1:0]   i_req_last;
   logic [NUM-1:0]   o_req_ready;
   logic [NUM-1:0]   o_grant;
   logic             o_wr;
   logic [7:0]       o_data;
   logic             i_busy;

   int tests  = 0;
   int failed = 0;
   int busy_len = 0;
   bit busy_force = 1'b0;
   int gap_pct = 0;
   bit mute [NUM];
   int wr_cnt = 0;

   logic [8:0] src_q [NUM][$];
   logic [7:0] exp_q [NUM][$];
   int         gnt_log [$];
   logic [7:0] line_log [$];
   logic [NUM-1:0] prev_grant = '0;

   uart_tx_arbiter #(
      .NUM_REQ (NUM)
   ) dut (
      .i_clk       (clk),
      .rst         (rst),
      .i_req_valid (i_req_valid),
      .i_req_data  (i_req_data),
      .i_req_last  (i_req_last),
      .o_req_ready (o_req_ready),
      .o_grant     (o_grant),
      .o_wr        (o_wr),
      .o_data      (o_data),
      .i_busy      (i_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   function automatic int idx_of(input logic [NUM-1:0] g);
      int r;
      r = 0;
      for (int i = 0; i < NUM; i++) if (g[i]) r = i;
      return r;
   endfunction

   function automatic bit all_empty();
      bit e;
      e = 1'b1;
      for (int k = 0; k < NUM; k++) if (src_q[k].size() != 0 || exp_q[k].size() != 0) e = 1'b0;
      return e;
   endfunction

   // Packet of n bytes, byte i taken from b[8i+7:8i]; the model line gets the tag first.
   task automatic push_pkt(input int k, input int n, input logic [31:0] b);
`ifdef UART_ARB_SRC_TAG_EN
      exp_q[k].push_back(TAG_BASE | 8'(k));
`endif
      for (int i = 0; i < n; i++) begin
         src_q[k].push_back({(i == n - 1), b[8*i +: 8]});
         exp_q[k].push_back(b[8*i +: 8]);
      end
   endtask

   task automatic wait_done(input int maxc, input string tag);
      int c;
      c = 0;
      do begin
         @(negedge clk);
         #1;
         c++;
      end while (!(all_empty() && o_grant == '0) && c < maxc);
      check(tag, 32'(all_empty() && o_grant == '0), 32'd1);
   endtask

   task automatic wait_wr(input int target, input int maxc, input string tag);
      int c;
      c = 0;
      do begin
         @(negedge clk);
         #1;
         c++;
      end while (wr_cnt < target && c < maxc);
      check(tag, 32'(wr_cnt >= target), 32'd1);
   endtask

   // Requester sources: pop on handshake, present head byte unless muted or gapping.
   initial begin : driver
      logic [NUM-1:0] hs;
      logic [8:0]     f;
      i_req_valid = '0;
      i_req_data  = '0;
      i_req_last  = '0;
      forever begin
         @(negedge clk);
         hs = i_req_valid & o_req_ready;
         @(posedge clk);
         #1;
         for (int k = 0; k < NUM; k++) begin
            if (hs[k] && !rst && src_q[k].size() > 0) void'(src_q[k].pop_front());
            if (src_q[k].size() > 0 && !mute[k] && int'($urandom_range(99)) >= gap_pct) begin
               f = src_q[k][0];
               i_req_valid[k]       = 1'b1;
               i_req_data[8*k +: 8] = f[7:0];
               i_req_last[k]        = f[8];
            end else begin
               i_req_valid[k]       = 1'b0;
               i_req_last[k]        = 1'b0;
               i_req_data[8*k +: 8] = 8'($urandom);
            end
         end
      end
   end

   // txuart stand-in: busy from the cycle after a strobe for busy_len cycles.
   initial begin : busy_model
      int cnt;
      bit pend;
      cnt = 0;
      pend = 1'b0;
      i_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            cnt = 0;
            pend = 1'b0;
         end else begin
            if (cnt > 0) cnt--;
            if (pend) cnt = busy_len;
            pend = o_wr;
         end
         i_busy = busy_force || (cnt > 0);
      end
   end

   // Line scoreboard: every strobed byte must be the next pending byte of the granted source.
   always @(negedge clk) begin
      int gi;
      if (rst) begin
         prev_grant = '0;
      end else begin
         if (o_grant != '0 && prev_grant == '0) gnt_log.push_back(idx_of(o_grant));
         prev_grant = o_grant;
         if (o_wr) begin
            wr_cnt++;
            line_log.push_back(o_data);
            gi = idx_of(o_grant);
            check("wr_grant_onehot", 32'($onehot(o_grant)), 32'd1);
            check("wr_pending", 32'(exp_q[gi].size() > 0), 32'd1);
            if (exp_q[gi].size() > 0) check("wr_byte", 32'(o_data), 32'(exp_q[gi].pop_front()));
         end
      end
   end

   initial begin : main
      int base;
      int viol;
      int tot;
      int k;
      int n;
      logic [7:0] exp_line [$];

      rst = 1'b1;
      for (int i = 0; i < NUM; i++) mute[i] = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_grant", 32'(o_grant), 32'd0);
      check("rst_ready", 32'(o_req_ready), 32'd0);
      check("rst_wr", 32'(o_wr), 32'd0);
      check("rst_data", 32'(o_data), 32'd0);
      rst = 1'b0;

      // All sources continuously valid: grants rotate 0,1,2,3,0,...
      gnt_log.delete();
      for (int r = 0; r < 2; r++)
         for (int j = 0; j < NUM; j++) push_pkt(j, 1, 32'(16 * (r + 1) + j));
      wait_done(400, "rot_done");
      check("rot_count", 32'(gnt_log.size()), 32'(2 * NUM));
      for (int i = 0; i < 2 * NUM; i++)
         if (i < gnt_log.size()) check("rot_order", 32'(gnt_log[i]), 32'(i % NUM));

      // Cycle-exact latency from idle with busy low.
      @(negedge clk);
      push_pkt(2, 1, 32'h77);
      @(posedge clk);
      #2;
      @(negedge clk);
      check("tm_t0_grant", 32'(o_grant), 32'd0);
      @(negedge clk);
      check("tm_t1_grant", 32'(o_grant), 32'b0100);
      check("tm_t1_ready", 32'(o_req_ready), (TAG_N != 0) ? 32'd0 : 32'b0100);
      @(negedge clk);
      check("tm_t2_wr", 32'(o_wr), 32'd1);
      check("tm_t2_data", 32'(o_data), (TAG_N != 0) ? 32'hA2 : 32'h77);
      wait_done(100, "tm_done");

      // Req1 three-byte packet paced by a 10-cycle busy.
      busy_len = 10;
      line_log.delete();
      push_pkt(1, 3, 32'h0033_2211);
      wait_done(400, "p3_done");
      exp_line.delete();
`ifdef UART_ARB_SRC_TAG_EN
      exp_line.push_back(8'hA1);
`endif
      exp_line.push_back(8'h11);
      exp_line.push_back(8'h22);
      exp_line.push_back(8'h33);
      check("p3_count", 32'(line_log.size()), 32'(exp_line.size()));
      for (int i = 0; i < exp_line.size(); i++)
         if (i < line_log.size()) check("p3_byte", 32'(line_log[i]), 32'(exp_line[i]));

      // Req0 stalls mid-packet while req2 waits; grant must stay with req0.
      busy_len = 0;
      gnt_log.delete();
      base = wr_cnt;
      push_pkt(0, 2, 32'h0000_B2B1);
      wait_wr(base + 1 + TAG_N, 200, "gap_first");
      mute[0] = 1'b1;
      push_pkt(2, 1, 32'hC2);
      viol = 0;
      repeat (20) begin
         @(negedge clk);
         if (o_grant !== 4'b0001 || o_req_ready[2] !== 1'b0) viol++;
      end
      check("gap_hold", 32'(viol), 32'd0);
      mute[0] = 1'b0;
      wait_done(200, "gap_done");
      check("gap_count", 32'(gnt_log.size()), 32'd2);
      if (gnt_log.size() > 1) begin
         check("gap_first_owner", 32'(gnt_log[0]), 32'd0);
         check("gap_second_owner", 32'(gnt_log[1]), 32'd2);
      end

      // Req3 single byte: tag byte only when the feature is built in.
      line_log.delete();
      push_pkt(3, 1, 32'h5A);
      wait_done(100, "tag_done");
      exp_line.delete();
`ifdef UART_ARB_SRC_TAG_EN
      exp_line.push_back(8'hA3);
`endif
      exp_line.push_back(8'h5A);
      check("tag_count", 32'(line_log.size()), 32'(exp_line.size()));
      for (int i = 0; i < exp_line.size(); i++)
         if (i < line_log.size()) check("tag_byte", 32'(line_log[i]), 32'(exp_line[i]));

      // Busy held high: no ready and no strobe until it falls.
      busy_force = 1'b1;
      base = wr_cnt;
      push_pkt(1, 2, 32'h0000_E2E1);
      repeat (4) @(negedge clk);
      viol = 0;
      repeat (100) begin
         @(negedge clk);
         if (o_req_ready != '0 || o_wr) viol++;
      end
      check("busy_quiet", 32'(viol), 32'd0);
      check("busy_nowr", 32'(wr_cnt - base), 32'd0);
      check("busy_grant", 32'(o_grant), 32'b0010);
      busy_force = 1'b0;
      wait_done(100, "busy_done");
      check("busy_bytes", 32'(wr_cnt - base), 32'(2 + TAG_N));

      // Reset during the strobe of the second payload byte.
      push_pkt(1, 3, 32'h00C3_C2C1);
      base = wr_cnt;
      wait_wr(base + 2 + TAG_N, 200, "rst_reach");
      check("rst_at_strobe", 32'(o_wr), 32'd1);
      rst = 1'b1;
      for (int j = 0; j < NUM; j++) begin
         src_q[j].delete();
         exp_q[j].delete();
      end
      @(negedge clk);
      check("rst_mid_wr", 32'(o_wr), 32'd0);
      check("rst_mid_grant", 32'(o_grant), 32'd0);
      check("rst_mid_ready", 32'(o_req_ready), 32'd0);
      rst = 1'b0;
      gnt_log.delete();
      base = wr_cnt;
      push_pkt(2, 1, 32'hD2);
      push_pkt(0, 1, 32'hD0);
      wait_done(200, "rst_after_done");
      check("rst_first_pick", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'd99, 32'd0);
      check("rst_after_bytes", 32'(wr_cnt - base), 32'(2 * (1 + TAG_N)));

      // Random packets, gaps and busy lengths.
      gap_pct = 30;
      base = wr_cnt;
      tot = 0;
      for (int p = 0; p < 40; p++) begin
         k = int'($urandom_range(NUM - 1));
         n = int'($urandom_range(4, 1));
         busy_len = int'($urandom_range(6));
         push_pkt(k, n, $urandom);
         tot += n + TAG_N;
         repeat ($urandom_range(10)) @(negedge clk);
      end
      wait_done(20000, "rand_done");
      check("rand_bytes", 32'(wr_cnt - base), 32'(tot));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
